// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Byte-stream program loader that sits upstream of the CPU wrapper. It parses a
// framed program image arriving from UART RX, packs the bytes into 32-bit
// little-endian words and writes them through the IMEM reload port. While a
// frame is being loaded, and after any failed load, the CPU is held in reset.
// The CPU is released only when a frame finishes with a matching checksum.
//
// Frame layout:
//   MAGIC, LEN_LO, LEN_HI, LEN*4 data bytes, CSUM
//   CSUM = XOR of LEN_LO, LEN_HI and every data byte
//
// Parameters:
//   BASE_ADDR    byte address of the first IMEM word written (bits [1:0] ignored)
//   NUM_WORDS    IMEM capacity in words; longer frames are rejected
//   TIMEOUT_CYC  maximum clk cycles allowed between accepted bytes inside a frame
//   MAGIC        frame start byte
//
// Ports:
//   clk            system clock
//   srst           synchronous reset, active-high
//   rx_vld         RX byte valid
//   rx_dat         RX byte
//   rx_rdy         byte accept (a byte is taken when rx_vld & rx_rdy)
//   imem_cpu_rstn  0 holds the CPU in reset (loading, or last load failed)
//   imem_we        IMEM write strobe, one-cycle pulse per word
//   imem_waddr     IMEM word address
//   imem_wdat      IMEM write data
//   busy           a frame is in progress
//   done           one-cycle pulse on a successful load
//   err            sticky flag: the last frame failed (size, checksum or timeout)
//   words_loaded   words written in the current or last frame
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_WORDS   = 8192,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]  MAGIC       = 8'hA5
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        rx_vld,
  input  logic [7:0]  rx_dat,
  output logic        rx_rdy,
  output logic        imem_cpu_rstn,
  output logic        imem_we,
  output logic [29:0] imem_waddr,
  output logic [31:0] imem_wdat,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM
  } state_t;

  // A 17-bit limit so a 16-bit length can be compared against 65536 as well.
  localparam logic [16:0] MAX_LEN  = 17'(NUM_WORDS);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [29:0] BASE_WA  = BASE_ADDR[31:2];

  state_t      state;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  byte_idx;
  logic [23:0] word_acc;
  logic [31:0] tmo_cnt;
  logic        accept;
  logic        tmo_hit;
  logic [15:0] words_next;

  // The loader never back-pressures; the only time it refuses bytes is while
  // it is being reset.
  assign rx_rdy = ~srst;
  assign accept = rx_vld & rx_rdy;
  assign busy   = (state != S_IDLE);

  // Timeout wins over a byte arriving in the same cycle, so that byte is lost.
  assign tmo_hit    = (state != S_IDLE) && (tmo_cnt == TMO_LAST);
  assign words_next = words_loaded + 16'd1;

  // Whole loader in one sequential block: the frame parser FSM, the checksum,
  // the word packer, the IMEM write port and the inter-byte timeout. The
  // write strobe and done are pulses and default low each cycle. The IMEM
  // address advances the cycle after each write so it is stable during the
  // pulse; a MAGIC byte later in this block overrides that with the base.
  always_ff @(posedge clk) begin
    if (srst) begin
      state         <= S_IDLE;
      imem_cpu_rstn <= 1'b1;
      imem_we       <= 1'b0;
      imem_waddr    <= BASE_WA;
      imem_wdat     <= 32'd0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_loaded  <= 16'd0;
      len           <= 16'd0;
      csum          <= 8'd0;
      byte_idx      <= 2'd0;
      word_acc      <= 24'd0;
      tmo_cnt       <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;

      if (imem_we) begin
        imem_waddr <= imem_waddr + 30'd1;
      end

      if ((state == S_IDLE) || accept) begin
        tmo_cnt <= 32'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      if (tmo_hit) begin
        state <= S_IDLE;
        err   <= 1'b1;
      end else if (accept) begin
        case (state)
          S_IDLE: begin
            if (rx_dat == MAGIC) begin
              state         <= S_LEN0;
              imem_cpu_rstn <= 1'b0;
              err           <= 1'b0;
              words_loaded  <= 16'd0;
              imem_waddr    <= BASE_WA;
              csum          <= 8'd0;
            end
          end

          S_LEN0: begin
            len[7:0] <= rx_dat;
            csum     <= csum ^ rx_dat;
            state    <= S_LEN1;
          end

          S_LEN1: begin
            len[15:8] <= rx_dat;
            csum      <= csum ^ rx_dat;
            if ({1'b0, rx_dat, len[7:0]} > MAX_LEN) begin
              state <= S_IDLE;
              err   <= 1'b1;
            end else if ({rx_dat, len[7:0]} == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state    <= S_DATA;
              byte_idx <= 2'd0;
            end
          end

          S_DATA: begin
            csum <= csum ^ rx_dat;
            if (byte_idx == 2'd3) begin
              imem_wdat    <= {rx_dat, word_acc};
              imem_we      <= 1'b1;
              words_loaded <= words_next;
              byte_idx     <= 2'd0;
              if (words_next == len) begin
                state <= S_CSUM;
              end
            end else begin
              word_acc[byte_idx*8 +: 8] <= rx_dat;
              byte_idx                  <= byte_idx + 2'd1;
            end
          end

          S_CSUM: begin
            state <= S_IDLE;
            if (rx_dat == csum) begin
              done          <= 1'b1;
              imem_cpu_rstn <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. A table of single-cycle byte vectors with
// hand-computed expected outputs covers whole frames (good, bad checksum,
// recovery, garbage plus empty frame). Hand-written sequences then cover the
// oversize rejection, the inter-byte timeout, reset in the middle of a frame
// and MAGIC bytes carried as ordinary data.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        srst;
  logic        rx_vld;
  logic [7:0]  rx_dat;
  logic        rx_rdy;
  logic        imem_cpu_rstn;
  logic        imem_we;
  logic [29:0] imem_waddr;
  logic [31:0] imem_wdat;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  imem_loader #(
    .BASE_ADDR   (32'h0000_0000),
    .NUM_WORDS   (8192),
    .TIMEOUT_CYC (TMO),
    .MAGIC       (8'hA5)
  ) dut (
    .clk           (clk),
    .srst          (srst),
    .rx_vld        (rx_vld),
    .rx_dat        (rx_dat),
    .rx_rdy        (rx_rdy),
    .imem_cpu_rstn (imem_cpu_rstn),
    .imem_we       (imem_we),
    .imem_waddr    (imem_waddr),
    .imem_wdat     (imem_wdat),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .words_loaded  (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        we;
    logic [29:0] waddr;
    logic [31:0] wdat;
    logic        done;
    logic        err;
    logic        rstn;
    logic        busy;
    logic [15:0] wl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Packs an expected output set, rx_rdy first.
  function automatic logic [83:0] expv(input logic rdy, input logic we,
                                       input logic [29:0] waddr, input logic [31:0] wdat,
                                       input logic dn, input logic er, input logic rstn,
                                       input logic bsy, input logic [15:0] wl);
    return {rdy, we, waddr, wdat, dn, er, rstn, bsy, wl};
  endfunction

  task automatic addVec(input logic vld, input logic [7:0] dat, input logic we,
                        input logic [29:0] waddr, input logic [31:0] wdat,
                        input logic dn, input logic er, input logic rstn,
                        input logic bsy, input logic [15:0] wl);
    vec_t v;
    v.vld = vld; v.dat = dat; v.we = we; v.waddr = waddr; v.wdat = wdat;
    v.done = dn; v.err = er; v.rstn = rstn; v.busy = bsy; v.wl = wl;
    vecs.push_back(v);
  endtask

  // Frame A5 02 00 11 22 33 44 55 66 77 88 <cs> followed by one idle cycle.
  // pw is the write data still held from before the frame.
  task automatic addFrameA(input logic [7:0] cs, input logic good, input logic [31:0] pw);
    addVec(1'b1, 8'hA5, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h02, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h00, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h11, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h22, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h33, 1'b0, 30'd0, pw, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h44, 1'b1, 30'd0, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    addVec(1'b1, 8'h55, 1'b0, 30'd1, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    addVec(1'b1, 8'h66, 1'b0, 30'd1, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    addVec(1'b1, 8'h77, 1'b0, 30'd1, 32'h4433_2211, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1);
    addVec(1'b1, 8'h88, 1'b1, 30'd1, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2);
    addVec(1'b1, cs,    1'b0, 30'd2, 32'h8877_6655, good, ~good, good, 1'b0, 16'd2);
    addVec(1'b0, 8'h00, 1'b0, 30'd2, 32'h8877_6655, 1'b0, ~good, good, 1'b0, 16'd2);
  endtask

  // Drives one cycle of input and returns 1 time unit after the clock edge.
  task automatic applyStimulus(input logic vld, input logic [7:0] dat);
    rx_vld = vld;
    rx_dat = dat;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [83:0] exp);
    logic [83:0] act;
    act = {rx_rdy, imem_we, imem_waddr, imem_wdat, done, err, imem_cpu_rstn, busy, words_loaded};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got rdy/we/waddr/wdat/done/err/rstn/busy/wl=%h required %h",
               name, act, exp);
    end
  endtask

  initial begin
    // Expected values: frame A checksum is 02^00^11^22^33^44^55^66^77^88 = 8A.
    addFrameA(8'h8A, 1'b1, 32'h0);
    addFrameA(8'h8B, 1'b0, 32'h8877_6655);
    addFrameA(8'h8A, 1'b1, 32'h8877_6655);
    // Garbage before MAGIC, then an empty frame with checksum 00.
    addVec(1'b1, 8'h00, 1'b0, 30'd2, 32'h8877_6655, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    addVec(1'b1, 8'hFF, 1'b0, 30'd2, 32'h8877_6655, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    addVec(1'b1, 8'h5A, 1'b0, 30'd2, 32'h8877_6655, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    addVec(1'b1, 8'hA5, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h00, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h00, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    addVec(1'b1, 8'h00, 1'b0, 30'd0, 32'h8877_6655, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    addVec(1'b0, 8'h00, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);

    // Reset: rx_rdy low while srst is held, reset values afterwards.
    srst   = 1'b1;
    rx_vld = 1'b0;
    rx_dat = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", expv(1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    srst = 1'b0;
    #1;
    checkOutput("reset_release", expv(1'b1, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].vld, vecs[i].dat);
      checkOutput($sformatf("vec%0d_byte%h", i, vecs[i].dat),
                  expv(1'b1, vecs[i].we, vecs[i].waddr, vecs[i].wdat, vecs[i].done,
                       vecs[i].err, vecs[i].rstn, vecs[i].busy, vecs[i].wl));
    end

    // Oversize: LEN = 0x2001 is rejected right after LEN_HI.
    applyStimulus(1'b1, 8'hA5);
    checkOutput("big_magic", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h20);
    checkOutput("big_reject", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));

    // LEN = 8192 exactly is accepted; stall after the second data byte.
    applyStimulus(1'b1, 8'hA5);
    checkOutput("max_magic", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h20);
    checkOutput("max_len_ok", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    for (int k = 1; k < int'(TMO); k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("stall%0d", k),
                  expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("timeout", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    applyStimulus(1'b1, 8'h33);
    checkOutput("after_timeout", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));

    // Reset in the middle of DATA.
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h11);
    checkOutput("pre_srst", expv(1'b1, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    srst   = 1'b1;
    rx_vld = 1'b1;
    rx_dat = 8'h22;
    #1;
    checkOutput("srst_rdy_low", expv(1'b0, 1'b0, 30'd0, 32'h8877_6655, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    @(posedge clk);
    #1;
    checkOutput("srst_mid_data", expv(1'b0, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));
    srst   = 1'b0;
    rx_vld = 1'b0;
    #1;
    checkOutput("srst_released", expv(1'b1, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0));

    // MAGIC bytes as payload: A5 01 00 A5 A5 A5 A5, checksum 01.
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b1, 8'hA5);
    applyStimulus(1'b1, 8'hA5);
    checkOutput("magic_data_mid", expv(1'b1, 1'b0, 30'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0));
    applyStimulus(1'b1, 8'hA5);
    checkOutput("magic_data_we", expv(1'b1, 1'b1, 30'd0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1));
    applyStimulus(1'b1, 8'h01);
    checkOutput("magic_data_done", expv(1'b1, 1'b0, 30'd1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1));
    applyStimulus(1'b0, 8'h00);
    checkOutput("magic_data_idle", expv(1'b1, 1'b0, 30'd1, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
